cpu_program_feeder: RTL and testbench

Host-side driver for the 8-bit hidden CPU pin interface. It buffers a short program of 6-bit instruction words, holds the CPU in reset while loading, then issues one instruction per clock on the CPU's `io_in[7:2]` lines. It captures the CPU's `io_out` byte after every retired instruction into a trace FIFO that the host drains with a valid/ready handshake.

---
 rtl/cpu_program_feeder.sv | 218 +++++++++++++++++++++
 tb/tb_cpu_program_feeder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_program_feeder.sv
// cpu_program_feeder: host-side driver for the 8-bit hidden CPU pin interface.
// Buffers a short program of 6-bit instruction words, holds the CPU in reset
// while loading, then issues one word per clock on the CPU instruction lines
// and captures the CPU output byte after every retired instruction into a
// first-word-fall-through trace FIFO drained with a valid/ready handshake.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   load_valid/data/ready    program word load handshake (IDLE only)
//   start                    begin (or re-run from DONE) execution
//   clear                    empty program buffer and trace FIFO, clear overflow
//   cpu_rst, cpu_instr       drive CPU io_in[1] and io_in[7:2]
//   cpu_out                  CPU io_out byte
//   trace_valid/data/ready   trace FIFO head and pop handshake
//   busy, done, overflow     status; overflow is sticky until run entry or clear
//   prog_len                 number of loaded program words
module cpu_program_feeder #(
  parameter int unsigned PROG_DEPTH  = 16,
  parameter int unsigned TRACE_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_valid,
  input  logic [5:0]                  load_data,
  output logic                        load_ready,
  input  logic                        start,
  input  logic                        clear,
  output logic                        cpu_rst,
  output logic [5:0]                  cpu_instr,
  input  logic [7:0]                  cpu_out,
  output logic                        trace_valid,
  output logic [7:0]                  trace_data,
  input  logic                        trace_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
  output logic [$clog2(PROG_DEPTH):0] prog_len
);

  localparam int unsigned IdxW   = $clog2(PROG_DEPTH);
  localparam int unsigned LenW   = IdxW + 1;
  localparam int unsigned PtrW   = $clog2(TRACE_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned InstrW = 6;
  localparam int unsigned DataW  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, stateNext;

  logic [InstrW-1:0] progMem  [PROG_DEPTH];
  logic [DataW-1:0]  traceMem [TRACE_DEPTH];

  logic [IdxW-1:0]   idx, idxNext;
  logic [LenW-1:0]   progLenNext;
  logic              pending, pendingNext;
  logic [PtrW-1:0]   wrPtr, wrPtrNext, rdPtr, rdPtrNext;
  logic [CntW-1:0]   count, countNext;

  logic              progWe;
  logic              pushReq;
  logic              clearFifo;
  logic              clearOvf;
  logic              pop;
  logic              full;
  logic              doPush;
  logic              drop;
  logic [InstrW-1:0] instrNext;
  logic [DataW-1:0]  headNext;
  logic              overflowNext;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state, sequencing and FIFO next-value logic
  always_comb begin
    stateNext    = state;
    idxNext      = idx;
    progLenNext  = prog_len;
    pendingNext  = pending;
    progWe       = 1'b0;
    pushReq      = 1'b0;
    clearFifo    = 1'b0;
    clearOvf     = 1'b0;
    instrNext    = '0;

    unique case (state)
      IDLE: begin
        if (clear) begin
          progLenNext = '0;
          pendingNext = 1'b0;
          clearFifo   = 1'b1;
        end else begin
          if (load_valid && load_ready) begin
            progWe      = 1'b1;
            progLenNext = prog_len + LenW'(1);
          end
          // pending carries a start that arrived in DONE through this reset cycle
          if ((start || pending) && (prog_len != '0)) begin
            stateNext   = RUN;
            idxNext     = '0;
            pendingNext = 1'b0;
            clearOvf    = 1'b1;
            instrNext   = progMem[0];
          end
        end
      end
      RUN: begin
        // result of the previous word is on cpu_out from the second cycle on
        pushReq = (idx != '0);
        if (LenW'(idx) == prog_len - LenW'(1)) begin
          stateNext = FLUSH;
        end else begin
          idxNext   = idx + IdxW'(1);
          instrNext = progMem[idx + IdxW'(1)];
        end
      end
      FLUSH: begin
        pushReq   = 1'b1;
        stateNext = DONE;
      end
      DONE: begin
        if (clear) begin
          stateNext   = IDLE;
          progLenNext = '0;
          pendingNext = 1'b0;
          clearFifo   = 1'b1;
        end else if (start) begin
          stateNext   = IDLE;
          pendingNext = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase

    // Trace FIFO: push and pop in one cycle are both honoured, even when full
    pop    = trace_ready && (count != '0);
    full   = (count == CntW'(TRACE_DEPTH));
    doPush = pushReq && (!full || pop);
    drop   = pushReq && full && !pop;

    rdPtrNext = pop    ? rdPtr + PtrW'(1) : rdPtr;
    wrPtrNext = doPush ? wrPtr + PtrW'(1) : wrPtr;
    countNext = count + CntW'(doPush) - CntW'(pop);
    if (clearFifo) begin
      rdPtrNext = '0;
      wrPtrNext = '0;
      countNext = '0;
    end

    // Head bypass: a push into an empty (after pop) FIFO becomes the head directly
    headNext = (doPush && (wrPtr == rdPtrNext)) ? cpu_out : traceMem[rdPtrNext];

    overflowNext = overflow;
    if (clearFifo || clearOvf) begin
      overflowNext = 1'b0;
    end else if (drop) begin
      overflowNext = 1'b1;
    end
  end

  // Control, pointer and registered output state
  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      prog_len    <= '0;
      pending     <= 1'b0;
      wrPtr       <= '0;
      rdPtr       <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      cpu_rst     <= 1'b1;
      cpu_instr   <= '0;
      load_ready  <= 1'b1;
      trace_valid <= 1'b0;
      trace_data  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      idx         <= idxNext;
      prog_len    <= progLenNext;
      pending     <= pendingNext;
      wrPtr       <= wrPtrNext;
      rdPtr       <= rdPtrNext;
      count       <= countNext;
      overflow    <= overflowNext;
      cpu_rst     <= (stateNext == IDLE);
      cpu_instr   <= instrNext;
      load_ready  <= (stateNext == IDLE) && (progLenNext < LenW'(PROG_DEPTH));
      trace_valid <= (countNext != '0);
      trace_data  <= headNext;
      busy        <= (stateNext == RUN) || (stateNext == FLUSH);
      done        <= (stateNext == DONE);
    end
  end

  // Storage arrays carry no reset; their contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (progWe) begin
      progMem[prog_len[IdxW-1:0]] <= load_data;
    end
    if (doPush) begin
      traceMem[wrPtr] <= cpu_out;
    end
  end

endmodule

// File: tb/tb_cpu_program_feeder.sv
// Directed bench for cpu_program_feeder with a small behavioural CPU model.
module tb_cpu_program_feeder;

  localparam int unsigned PD = 16;
  localparam int unsigned TD = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid;
  logic [5:0] load_data;
  logic       load_ready;
  logic       start;
  logic       clear;
  logic       cpu_rst;
  logic [5:0] cpu_instr;
  logic [7:0] cpu_out;
  logic       trace_valid;
  logic [7:0] trace_data;
  logic       trace_ready;
  logic       busy;
  logic       done;
  logic       overflow;
  logic [4:0] prog_len;

  always #5 clk = ~clk;

  cpu_program_feeder #(.PROG_DEPTH(PD), .TRACE_DEPTH(TD)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .start(start), .clear(clear),
    .cpu_rst(cpu_rst), .cpu_instr(cpu_instr), .cpu_out(cpu_out),
    .trace_valid(trace_valid), .trace_data(trace_data), .trace_ready(trace_ready),
    .busy(busy), .done(done), .overflow(overflow), .prog_len(prog_len)
  );

  int nTests = 0;
  int nFail  = 0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // CPU model: regs r0..r3 (packed {r3,r2,r1,r0}); instr {op,dst,src};
  // op 0 add, 1 sub, 2 xor, 3 mov; io_out = {op, dst, result[3:0]}
  function automatic logic [39:0] cpuStep(input logic [31:0] regs, input logic [5:0] instr);
    logic [1:0]  op;
    logic [1:0]  d;
    logic [1:0]  s;
    logic [7:0]  rd;
    logic [7:0]  rs;
    logic [7:0]  res;
    logic [31:0] nr;
    op = instr[5:4];
    d  = instr[3:2];
    s  = instr[1:0];
    rd = regs[int'(d)*8 +: 8];
    rs = regs[int'(s)*8 +: 8];
    case (op)
      2'd0:    res = rd + rs;
      2'd1:    res = rd - rs;
      2'd2:    res = rd ^ rs;
      default: res = rs;
    endcase
    nr = regs;
    nr[int'(d)*8 +: 8] = res;
    return {nr, op, d, res[3:0]};
  endfunction

  logic [31:0] cpuRegs;
  always @(posedge clk) begin
    if (cpu_rst) begin
      cpuRegs <= 32'h03020100;
      cpu_out <= 8'h00;
    end else begin
      {cpuRegs, cpu_out} <= cpuStep(cpuRegs, cpu_instr);
    end
  end

  // Handshake monitor: record every popped head
  logic [7:0] gotQ[$];
  always @(posedge clk) begin
    if (trace_valid && trace_ready) gotQ.push_back(trace_data);
  end

  logic [5:0] prog16 [17];
  logic [7:0] exp16  [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitDone(input string tag, input int budget, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < budget) begin
      tick();
      cyc++;
    end
    checkEq({tag, "_done"}, 32'(done), 1);
  endtask

  task automatic checkTrace16(input string tag);
    checkEq({tag, "_count"}, 32'(gotQ.size()), 16);
    for (int i = 0; i < 16 && i < gotQ.size(); i++) begin
      checkEq($sformatf("%s[%0d]", tag, i), 32'(gotQ[i]), 32'(exp16[i]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] w3 [3];
    logic [5:0] i1 [6];
    logic [31:0] regs;
    logic [7:0]  o;
    int cyc;

    w3 = '{6'h04, 6'h19, 6'h2E};
    i1 = '{6'h00, 6'h04, 6'h19, 6'h2E, 6'h00, 6'h00};
    for (int i = 0; i < 17; i++) prog16[i] = 6'((i * 7 + 5) % 64);
    regs = 32'h03020100;
    for (int i = 0; i < 16; i++) begin
      {regs, o} = cpuStep(regs, prog16[i]);
      exp16[i] = o;
    end

    rst = 1'b1; load_valid = 1'b0; load_data = '0; start = 1'b0;
    clear = 1'b0; trace_ready = 1'b0;
    tick(); tick();
    checkEq("rst_cpu_rst",    32'(cpu_rst), 1);
    checkEq("rst_cpu_instr",  32'(cpu_instr), 0);
    checkEq("rst_load_ready", 32'(load_ready), 1);
    checkEq("rst_trace_valid",32'(trace_valid), 0);
    checkEq("rst_busy",       32'(busy), 0);
    checkEq("rst_done",       32'(done), 0);
    checkEq("rst_overflow",   32'(overflow), 0);
    checkEq("rst_prog_len",   32'(prog_len), 0);
    rst = 1'b0;
    tick();

    // start with empty program is ignored
    start = 1'b1; tick(); start = 1'b0;
    checkEq("empty_start_busy", 32'(busy), 0);
    checkEq("empty_start_rst",  32'(cpu_rst), 1);
    tick();
    checkEq("empty_start_busy2", 32'(busy), 0);

    // load 3 words and run
    load_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      load_data = w3[i];
      tick();
    end
    load_valid = 1'b0;
    checkEq("t1_prog_len", 32'(prog_len), 3);
    gotQ.delete();
    trace_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      checkEq($sformatf("t1_cpu_rst_c%0d", c), 32'(cpu_rst), 0);
      checkEq($sformatf("t1_done_c%0d", c), 32'(done), 32'(c == 5));
      checkEq($sformatf("t1_busy_c%0d", c), 32'(busy), 32'(c <= 4));
      checkEq($sformatf("t1_instr_c%0d", c), 32'(cpu_instr), 32'(i1[c]));
      checkEq($sformatf("t1_tvalid_c%0d", c), 32'(trace_valid), 32'(c >= 3));
      if (c < 5) tick();
    end
    tick(); tick(); tick();
    checkEq("t1_count", 32'(gotQ.size()), 3);
    if (gotQ.size() == 3) begin
      checkEq("t1_s0", 32'(gotQ[0]), 32'h11);
      checkEq("t1_s1", 32'(gotQ[1]), 32'h61);
      checkEq("t1_s2", 32'(gotQ[2]), 32'hB2);
    end
    checkEq("t1_drained", 32'(trace_valid), 0);

    // clear from DONE, then load 17 words into a 16-entry buffer
    clear = 1'b1; tick(); clear = 1'b0;
    checkEq("clr_done",     32'(done), 0);
    checkEq("clr_cpu_rst",  32'(cpu_rst), 1);
    checkEq("clr_prog_len", 32'(prog_len), 0);
    checkEq("clr_ready",    32'(load_ready), 1);
    load_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      checkEq($sformatf("full_ready_%0d", i), 32'(load_ready), 32'(i < 16));
      load_data = prog16[i];
      tick();
    end
    load_valid = 1'b0;
    checkEq("full_prog_len", 32'(prog_len), 16);
    checkEq("full_ready_low", 32'(load_ready), 0);
    gotQ.delete();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checkEq($sformatf("full_instr_%0d", i), 32'(cpu_instr), 32'(prog16[i]));
      tick();
    end
    checkEq("full_flush_busy",  32'(busy), 1);
    checkEq("full_flush_instr", 32'(cpu_instr), 0);
    checkEq("full_flush_done",  32'(done), 0);
    tick();
    checkEq("full_done", 32'(done), 1);
    tick(); tick(); tick();
    checkTrace16("full_trace");

    // overflow: fill the FIFO, then re-run with nobody draining
    gotQ.delete();
    trace_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    checkEq("ovf_rerun_cpu_rst", 32'(cpu_rst), 1);
    checkEq("ovf_rerun_busy",    32'(busy), 0);
    tick();
    checkEq("ovf_run1_instr0", 32'(cpu_instr), 32'(prog16[0]));
    waitDone("ovf_run1", 40, cyc);
    checkEq("ovf_run1_cycles", 32'(cyc), 17);
    checkEq("ovf_run1_flag",   32'(overflow), 0);
    checkEq("ovf_run1_valid",  32'(trace_valid), 1);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    waitDone("ovf_run2", 40, cyc);
    checkEq("ovf_run2_flag", 32'(overflow), 1);
    checkEq("ovf_run2_none_popped", 32'(gotQ.size()), 0);
    trace_ready = 1'b1;
    repeat (20) tick();
    trace_ready = 1'b0;
    checkTrace16("ovf_trace");
    checkEq("ovf_sticky", 32'(overflow), 1);

    // full FIFO with a pop on every capture cycle: nothing dropped
    gotQ.delete();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    waitDone("pp_fill", 40, cyc);
    checkEq("pp_fill_flag", 32'(overflow), 0);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    trace_ready = 1'b1;
    repeat (16) tick();
    trace_ready = 1'b0;
    checkEq("pp_done",  32'(done), 1);
    checkEq("pp_flag",  32'(overflow), 0);
    checkEq("pp_valid", 32'(trace_valid), 1);
    checkTrace16("pp_popped");
    gotQ.delete();
    trace_ready = 1'b1;
    repeat (20) tick();
    checkTrace16("pp_remaining");

    // start and clear during RUN are ignored
    gotQ.delete();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    start = 1'b1; clear = 1'b1; tick(); start = 1'b0; clear = 1'b0;
    checkEq("ign_busy",     32'(busy), 1);
    checkEq("ign_prog_len", 32'(prog_len), 16);
    waitDone("ign", 40, cyc);
    checkEq("ign_cycles", 32'(cyc), 15);
    tick(); tick(); tick();
    checkTrace16("ign_trace");
    checkEq("ign_prog_len_after", 32'(prog_len), 16);

    // reset in the third RUN cycle
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    checkEq("mid_pre_busy",   32'(busy), 1);
    checkEq("mid_pre_tvalid", 32'(trace_valid), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    checkEq("mid_cpu_rst",  32'(cpu_rst), 1);
    checkEq("mid_prog_len", 32'(prog_len), 0);
    checkEq("mid_tvalid",   32'(trace_valid), 0);
    checkEq("mid_busy",     32'(busy), 0);
    checkEq("mid_done",     32'(done), 0);
    checkEq("mid_overflow", 32'(overflow), 0);
    checkEq("mid_instr",    32'(cpu_instr), 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
